// File: rtl/omsp_hmac_arbiter.sv
// rtl/omsp_hmac_arbiter.sv - round-robin session arbiter and command sequencer for one omsp_hmac engine
module omsp_hmac_arbiter #(
    parameter int NREQ     = 2,
    parameter int KEY_SIZE = 128,
    parameter int RATE     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*KEY_SIZE-1:0] key_in,
    input  logic [NREQ-1:0]          op_valid,
    input  logic [NREQ-1:0]          op_data_avail,
    input  logic [NREQ*RATE-1:0]     op_data,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          op_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [RATE-1:0]          rsp_data,
    output logic                     hmac_start_continue,
    output logic                     hmac_data_available,
    output logic [RATE-1:0]          hmac_data_in,
    output logic [0:KEY_SIZE-1]      hmac_key,
    input  logic                     hmac_busy,
    input  logic [RATE-1:0]          hmac_data_out,
    output logic                     hmac_clear
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {IDLE, SESSION, ISSUE, WAIT, CLEAR} state_t;

    state_t                state, state_next;
    logic [IW-1:0]         last;
    logic [KEY_SIZE-1:0]   key_reg;
    logic                  abort, abort_next;
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic                  grant_now, accept, respond, enter_clear;

    // During a session `last` doubles as the index of the granted requester.
    always_comb begin
        state_next  = state;
        abort_next  = abort;
        pick_found  = 1'b0;
        pick_idx    = '0;
        grant_now   = 1'b0;
        accept      = 1'b0;
        respond     = 1'b0;
        enter_clear = 1'b0;

        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (int'(last) + k) % NREQ;
            if (!pick_found && req[j]) begin
                pick_found = 1'b1;
                pick_idx   = j[IW-1:0];
            end
        end

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_now  = 1'b1;
                    state_next = SESSION;
                end
            end
            SESSION: begin
                if (!req[last]) begin
                    enter_clear = 1'b1;
                    state_next  = CLEAR;
                end else if (op_valid[last]) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!req[last]) abort_next = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A request dropped mid-command is remembered so the engine finishes before the clear.
                if (!req[last]) abort_next = 1'b1;
                if (!hmac_busy) begin
                    if (abort_next) begin
                        enter_clear = 1'b1;
                        state_next  = CLEAR;
                    end else begin
                        respond    = 1'b1;
                        state_next = SESSION;
                    end
                end
            end
            CLEAR: begin
                abort_next = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            abort               <= 1'b0;
            last                <= IW'(NREQ - 1);
            key_reg             <= '0;
            gnt                 <= '0;
            rsp_valid           <= '0;
            rsp_data            <= '0;
            hmac_start_continue <= 1'b0;
            hmac_data_available <= 1'b0;
            hmac_data_in        <= '0;
            hmac_clear          <= 1'b0;
        end else begin
            state               <= state_next;
            abort               <= abort_next;
            hmac_start_continue <= accept;
            hmac_clear          <= enter_clear;
            rsp_valid           <= respond ? gnt : '0;
            if (grant_now) begin
                gnt     <= NREQ'(1) << pick_idx;
                key_reg <= key_in[pick_idx*KEY_SIZE +: KEY_SIZE];
                last    <= pick_idx;
            end
            // Grant and key drop together with the clear pulse so no key survives the session.
            if (enter_clear) begin
                gnt     <= '0;
                key_reg <= '0;
            end
            if (accept) begin
                hmac_data_available <= op_data_avail[last];
                hmac_data_in        <= op_data[last*RATE +: RATE];
            end
            if (respond) rsp_data <= hmac_data_out;
        end
    end

    assign op_ready = (state == SESSION) ? gnt : '0;
    assign hmac_key = key_reg;

endmodule

// File: tb/tb_omsp_hmac_arbiter.sv
// tb/tb_omsp_hmac_arbiter.sv - directed self-checking bench for omsp_hmac_arbiter
module tb_omsp_hmac_arbiter;
    localparam int NREQ = 2;
    localparam int KS   = 128;
    localparam int RATE = 8;
    localparam logic [KS-1:0] KEY_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [KS-1:0] KEY_B = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*KS-1:0] key_in = '0;
    logic [NREQ-1:0]   op_valid = '0;
    logic [NREQ-1:0]   op_data_avail = '0;
    logic [NREQ*RATE-1:0] op_data = '0;
    logic [NREQ-1:0]   gnt, op_ready, rsp_valid;
    logic [RATE-1:0]   rsp_data;
    logic              hmac_start_continue, hmac_data_available, hmac_clear;
    logic [RATE-1:0]   hmac_data_in;
    logic [0:KS-1]     hmac_key;
    logic              hmac_busy = 1'b0;
    logic [RATE-1:0]   hmac_data_out = '0;

    int checks = 0;
    int errors = 0;
    int eng_len = 0;
    int eng_cnt = 0;
    int eng_starts = 0;

    omsp_hmac_arbiter #(.NREQ(NREQ), .KEY_SIZE(KS), .RATE(RATE)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .key_in(key_in),
        .op_valid(op_valid), .op_data_avail(op_data_avail), .op_data(op_data),
        .gnt(gnt), .op_ready(op_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .hmac_start_continue(hmac_start_continue), .hmac_data_available(hmac_data_available),
        .hmac_data_in(hmac_data_in), .hmac_key(hmac_key), .hmac_busy(hmac_busy),
        .hmac_data_out(hmac_data_out), .hmac_clear(hmac_clear)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] eng_fn(input logic [7:0] d);
        return {d[3:0], d[7:4]} ^ 8'h96;
    endfunction

    // Engine stand-in: busy for eng_len WAIT cycles after each start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (hmac_start_continue) begin
                eng_cnt = eng_len;
                eng_starts++;
                hmac_data_out = eng_fn(hmac_data_in);
            end else begin
                hmac_busy = (eng_cnt > 0);
                if (eng_cnt > 0) eng_cnt--;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input int i, input logic av, input logic [7:0] d, input int len);
        eng_len = len;
        op_valid = '0;
        op_valid[i] = 1'b1;
        op_data_avail[i] = av;
        op_data[i*RATE +: RATE] = d;
        tick();
        op_valid = '0;
    endtask

    task automatic wait_rsp(output int n, output logic [NREQ-1:0] rv, output logic cl);
        n = 0;
        do begin
            tick();
            n++;
        end while (n < 40 && rsp_valid == '0 && !hmac_clear);
        rv = rsp_valid;
        cl = hmac_clear;
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        req = '0;
        op_valid = '0;
        eng_cnt = 0;
        hmac_busy = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        key_in = {KEY_B, KEY_A};
        reset_n = 1'b0;
        tick();
        checks++;
        if ({gnt, op_ready, rsp_valid, rsp_data, hmac_start_continue, hmac_data_available,
             hmac_data_in, hmac_clear} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b rdy=%b rv=%b sc=%b clr=%b exp all 0",
                     gnt, op_ready, rsp_valid, hmac_start_continue, hmac_clear);
        end
        checks++;
        if (hmac_key !== '0) begin
            errors++;
            $display("FAIL reset_key got %h exp 0", hmac_key);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_req got %b exp 00", gnt);
        end
    endtask

    task automatic test_single;
        int n, s0;
        logic [NREQ-1:0] rv;
        logic cl;
        req = 2'b01;
        tick();
        checks++;
        if (gnt !== 2'b01 || op_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant got gnt=%b rdy=%b exp 01/01", gnt, op_ready);
        end
        checks++;
        if (hmac_key !== KEY_A) begin
            errors++;
            $display("FAIL single_key got %h exp %h", hmac_key, KEY_A);
        end
        s0 = eng_starts;
        drive_cmd(0, 1'b1, 8'h5A, 4);
        checks++;
        if (hmac_start_continue !== 1'b1 || hmac_data_in !== 8'h5A || hmac_data_available !== 1'b1) begin
            errors++;
            $display("FAIL single_issue got sc=%b din=%h av=%b exp 1/5a/1",
                     hmac_start_continue, hmac_data_in, hmac_data_available);
        end
        wait_rsp(n, rv, cl);
        checks++;
        if (rv !== 2'b01 || n != 6 || rsp_data !== 8'h33) begin
            errors++;
            $display("FAIL single_rsp got rv=%b lat=%0d data=%h exp 01/6/33", rv, n, rsp_data);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00 || eng_starts != s0 + 1) begin
            errors++;
            $display("FAIL single_once got rv=%b starts=%0d exp 00/%0d", rsp_valid, eng_starts - s0, 1);
        end
        req = 2'b00;
        tick();
        checks++;
        if (hmac_clear !== 1'b1 || gnt !== 2'b00 || hmac_key !== '0) begin
            errors++;
            $display("FAIL single_clear got clr=%b gnt=%b key=%h exp 1/00/0", hmac_clear, gnt, hmac_key);
        end
        tick();
        checks++;
        if (hmac_clear !== 1'b0) begin
            errors++;
            $display("FAIL single_clear_pulse got %b exp 0", hmac_clear);
        end
    endtask

    task automatic test_round_robin;
        apply_reset();
        req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL rr_first got %b exp 01", gnt);
        end
        req = 2'b10;
        tick();
        checks++;
        if (hmac_clear !== 1'b1 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL rr_clear got clr=%b gnt=%b exp 1/00", hmac_clear, gnt);
        end
        tick();
        checks++;
        if (hmac_clear !== 1'b0 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL rr_gap got clr=%b gnt=%b exp 0/00", hmac_clear, gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b10 || hmac_key !== KEY_B) begin
            errors++;
            $display("FAIL rr_second got gnt=%b key=%h exp 10/%h", gnt, hmac_key, KEY_B);
        end
        req = 2'b00;
        tick();
        tick();
        req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01 || hmac_key !== KEY_A) begin
            errors++;
            $display("FAIL rr_wrap got gnt=%b key=%h exp 01/%h", gnt, hmac_key, KEY_A);
        end
    endtask

    task automatic test_ignore_other;
        int s0;
        logic bad;
        s0 = eng_starts;
        bad = 1'b0;
        eng_len = 1;
        op_valid = 2'b10;
        op_data_avail = 2'b10;
        op_data[15:8] = 8'h77;
        repeat (4) begin
            tick();
            if (hmac_start_continue !== 1'b0 || rsp_valid !== 2'b00) bad = 1'b1;
        end
        op_valid = '0;
        checks++;
        if (bad || gnt !== 2'b01 || eng_starts != s0) begin
            errors++;
            $display("FAIL ignore_other got bad=%b gnt=%b starts=%0d exp 0/01/0", bad, gnt, eng_starts - s0);
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_abort_wait;
        int n;
        logic [NREQ-1:0] rv;
        logic cl;
        req = 2'b01;
        tick();
        drive_cmd(0, 1'b1, 8'hC3, 5);
        tick();
        req = 2'b00;
        wait_rsp(n, rv, cl);
        checks++;
        if (rv !== 2'b00 || cl !== 1'b1 || n != 6) begin
            errors++;
            $display("FAIL abort_wait got rv=%b clr=%b lat=%0d exp 00/1/6", rv, cl, n);
        end
        checks++;
        if (hmac_key !== '0 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL abort_key got key=%h gnt=%b exp 0/00", hmac_key, gnt);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int n, cnt;
        logic [NREQ-1:0] rv;
        logic cl;
        logic [7:0] d;
        cnt = 0;
        req = 2'b01;
        tick();
        for (int i = 0; i < 18; i++) begin
            d = 8'(i * 29 + 7);
            drive_cmd(0, (i == 0), d, i % 3);
            wait_rsp(n, rv, cl);
            if (rv == 2'b01) cnt++;
            checks++;
            if (rv !== 2'b01 || rsp_data !== eng_fn(d) || n != (i % 3) + 2 || op_ready !== 2'b01) begin
                errors++;
                $display("FAIL b2b_cmd%0d got rv=%b data=%h lat=%0d rdy=%b exp 01/%h/%0d/01",
                         i, rv, rsp_data, n, op_ready, eng_fn(d), (i % 3) + 2);
            end
        end
        checks++;
        if (cnt != 18) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 18", cnt);
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_async_reset;
        req = 2'b01;
        tick();
        drive_cmd(0, 1'b1, 8'h11, 10);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, op_ready, rsp_valid, rsp_data, hmac_start_continue, hmac_data_available,
             hmac_data_in, hmac_clear} !== '0 || hmac_key !== '0) begin
            errors++;
            $display("FAIL async_reset got gnt=%b rv=%b clr=%b key=%h exp all 0",
                     gnt, rsp_valid, hmac_clear, hmac_key);
        end
        eng_cnt = 0;
        hmac_busy = 1'b0;
        req = 2'b00;
        tick();
        reset_n = 1'b1;
        req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01 || hmac_clear !== 1'b0) begin
            errors++;
            $display("FAIL async_rearb got gnt=%b clr=%b exp 01/0", gnt, hmac_clear);
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ignore_other();
        test_abort_wait();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/omsp_hmac_arbiter.md
# omsp_hmac_arbiter

Round-robin arbiter and sequencer sharing one `omsp_hmac` engine between `NREQ` requesters, e.g. the SM key-derivation unit and the MAC-verify unit. A granted requester owns the engine for a whole session, until it drops its request. The block latches that requester's key and issues single-cycle `start_continue` commands to the engine. It returns engine output per command and clears the engine and the latched key at every session end.

## Interface
- `NREQ`, 2: number of requesters, 2..4.
- `KEY_SIZE`, 128: key width; must match the engine.
- `RATE`, 8: engine data width; must match the engine.
- `clk` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req` in NREQ: session request; held high for the whole session.
- `key_in` in NREQ*KEY_SIZE: requester i key at `[i*KEY_SIZE +: KEY_SIZE]`.
- `op_valid` in NREQ: command valid.
- `op_data_avail` in NREQ: command carries data; maps to the engine's `data_available`.
- `op_data` in NREQ*RATE: requester i data at `[i*RATE +: RATE]`.
- `gnt` out NREQ: one-hot session grant, registered.
- `op_ready` out NREQ: `gnt[i]` while in SESSION.
- `rsp_valid` out NREQ: one-cycle, one-hot command completion.
- `rsp_data` out RATE: engine `data_out` captured at completion.
- `hmac_start_continue` out 1, `hmac_data_available` out 1, `hmac_data_in` out RATE, `hmac_key` out KEY_SIZE (`[0:KEY_SIZE-1]`, passed bit-for-bit): engine command port, all registered.
- `hmac_busy` in 1, `hmac_data_out` in RATE: engine status and output.
- `hmac_clear` out 1: one-cycle engine reset pulse, ORed into the engine reset by the integrator.

## Operation
- FSM states: IDLE, SESSION, ISSUE, WAIT, CLEAR.
- IDLE
  - If any `req` is set: pick the first set bit searching from `last+1` modulo NREQ.
  - Next cycle: `gnt` = that one-hot, `key_reg` <= that requester's key, `last` <= its index, go to SESSION.
- SESSION
  - `op_valid[g] & op_ready[g]` accepts a command. Capture `op_data_avail[g]` and `op_data[g]`, go to ISSUE.
  - `~req[g]` (higher priority than `op_valid`) goes to CLEAR.
  - Other requesters' `op_valid` is ignored.
- ISSUE: `hmac_start_continue`=1 for exactly this cycle, with captured `data_available`/`data_in`; go to WAIT.
- WAIT
  - Stay while `hmac_busy`=1.
  - On the first cycle with `hmac_busy`=0: `rsp_valid[g]`=1 and `rsp_data`=`hmac_data_out`, both registered and visible the next cycle; return to SESSION.
  - If `req[g]` fell during ISSUE/WAIT: suppress `rsp_valid` and go to CLEAR instead.
- CLEAR: `hmac_clear`=1 for one cycle, `key_reg` <= 0, `gnt` <= 0; go to IDLE.
- `hmac_key` = `key_reg` at all times; it is zero outside a session. Key material never leaks between requesters.
- `last` starts at NREQ-1, so requester 0 wins the first arbitration.

## Timing
- Reset values: all outputs 0, `key_reg`=0, `last`=NREQ-1, state IDLE. Asynchronous reset mid-session aborts with no response and no `hmac_clear` pulse; system reset resets the engine directly.
- Grant latency: `req` seen in IDLE at cycle t gives `gnt` high at t+1.
- Command path:
  - Accept at cycle t.
  - `hmac_start_continue` at t+1.
  - `hmac_busy` first sampled at t+2.
  - If busy is low at t+k, `rsp_valid` is high at t+k+1.
  - Minimum accept-to-response: 3 cycles. The next command may be accepted in the `rsp_valid` cycle.
- Session end: `req` low in SESSION at t gives `hmac_clear` at t+1 and IDLE at t+2. A new grant needs one more cycle, so `gnt` is low for at least 2 cycles between sessions.
- Simultaneous requests: resolved round-robin only in IDLE. There is no preemption, so a requester holding `req` never loses the engine.
- `op_valid` on a non-granted line: no effect, no response.

## Test plan
- `req`=01, key A, one data command 0x5A with busy held 4 cycles → `gnt`=01 at t+1. `hmac_start_continue` with `data_in`=0x5A once. `rsp_valid`=01 one cycle after busy falls.
- `req`=11 asserted together → `gnt`=01. After req0 drops: `hmac_clear` one cycle, `gnt`=00 for 2 cycles, then `gnt`=10. After req1 drops and both re-request: `gnt`=01.
- Full session, 128-bit key: 1 data command, 1 pad command (`op_data_avail`=0), then 16 output commands → 18 responses. `rsp_data` matches the reference HMAC-SPONGENT digest byte-for-byte.
- req drops while WAIT busy → no `rsp_valid`. `hmac_clear` pulses after busy falls. `hmac_key`=0 afterwards.
- `reset_n` low mid-WAIT → all outputs 0 immediately, state IDLE. `key_reg`=0 and `last`=NREQ-1, so the next arbitration grants requester 0.
- `op_valid`=10 while `gnt`=01 → no engine command, no response, `gnt` unchanged.
